// File: rtl/alu_op_sequencer_if.sv
// Bundles the command channel, ALU operand/select port and result FIFO channel
// between the ALU operation sequencer and its host.
interface alu_op_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_a;
    logic [1:0]       cmd_b;
    logic             sweep_start;
    logic [1:0]       alu_a;
    logic [1:0]       alu_b;
    logic [1:0]       alu_s;
    logic [3:0]       alu_out;
    logic             res_valid;
    logic             res_ready;
    logic [9:0]       res_data;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, sweep_start, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, fifo_count, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, sweep_start, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, fifo_count, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a 2-bit combinational ALU from single host commands or an exhaustive
// 64-step sweep, and queues {S,A,B,result} entries in a small result FIFO.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SWEEP} state_e;

    state_e           state_q, state_d;
    logic [1:0]       aluA_q, aluA_d;
    logic [1:0]       aluB_q, aluB_d;
    logic [1:0]       aluS_q, aluS_d;
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             notFull, nonEmpty, push, pop;
    logic [5:0]       sweepIdx;
    logic [9:0]       pushData;

    assign notFull  = count_q < DEPTH_C;
    assign nonEmpty = count_q != '0;
    assign pop      = nonEmpty && bus.res_ready;
    assign sweepIdx = {aluS_q, aluA_q, aluB_q};
    assign pushData = {aluS_q, aluA_q, aluB_q, bus.alu_out};

    // Sweep advance is gated by the registered count, so a same-cycle pop never
    // lets a push slip into a full FIFO.
    always_comb begin
        state_d = state_q;
        aluA_d  = aluA_q;
        aluB_d  = aluB_q;
        aluS_d  = aluS_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sweep_start) begin
                    state_d                  = SWEEP;
                    {aluS_d, aluA_d, aluB_d} = 6'd0;
                end else if (bus.cmd_valid && notFull) begin
                    state_d = DRIVE;
                    aluS_d  = bus.cmd_op;
                    aluA_d  = bus.cmd_a;
                    aluB_d  = bus.cmd_b;
                end
            end
            DRIVE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            SWEEP: begin
                if (notFull) begin
                    push = 1'b1;
                    if (sweepIdx == 6'd63) begin
                        state_d                  = IDLE;
                        {aluS_d, aluA_d, aluB_d} = 6'd0;
                    end else begin
                        {aluS_d, aluA_d, aluB_d} = sweepIdx + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aluA_q  <= '0;
            aluB_q  <= '0;
            aluS_q  <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            aluA_q  <= aluA_d;
            aluB_q  <= aluB_d;
            aluS_q  <= aluS_d;
            count_q <= count_d;
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= pushData;
    end

    assign bus.cmd_ready  = rst_n && (state_q == IDLE) && notFull;
    assign bus.alu_a      = aluA_q;
    assign bus.alu_b      = aluB_q;
    assign bus.alu_s      = aluS_q;
    assign bus.res_valid  = nonEmpty;
    assign bus.res_data   = nonEmpty ? mem_q[rdPtr_q] : 10'd0;
    assign bus.fifo_count = count_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random stimulus for alu_op_sequencer, checked every cycle against
// a transaction-level model (expected-result queue plus sweep/pending bookkeeping).
module tb_alu_op_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_op_sequencer_if #(.CNT_W(CNT_W)) bus ();

    alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] aluRef(input logic [1:0] s, input logic [1:0] a, input logic [1:0] b);
        logic [3:0] ea, eb;
        ea = {2'b00, a};
        eb = {2'b00, b};
        case (s)
            2'd0:    return {2'b00, ~a};
            2'd1:    return {2'b00, ~(a & b)};
            2'd2:    return ea + eb;
            default: return ea * eb;
        endcase
    endfunction

    assign bus.alu_out = aluRef(bus.alu_s, bus.alu_a, bus.alu_b);

    logic [9:0] expQ [$];
    bit         sweeping;
    int         sweepIdx;
    bit         pending;
    logic [5:0] pendCmd;
    logic [5:0] lastAlu;

    function automatic logic [9:0] entryOf(input logic [5:0] sab);
        return {sab, aluRef(sab[5:4], sab[3:2], sab[1:0])};
    endfunction

    function automatic logic expCmdReady();
        return (rst_n === 1'b1) && !sweeping && !pending && (expQ.size() < FIFO_DEPTH);
    endfunction

    task automatic modelReset();
        expQ.delete();
        sweeping = 1'b0;
        sweepIdx = 0;
        pending  = 1'b0;
        pendCmd  = '0;
        lastAlu  = '0;
    endtask

    // One clock edge of the abstract behaviour, using the inputs the DUT sampled.
    task automatic modelStep();
        int         preSize;
        bit         doPush;
        bit         doPop;
        logic [5:0] pushSab;
        preSize = expQ.size();
        doPush  = 1'b0;
        pushSab = '0;
        doPop   = (bus.res_ready === 1'b1) && (preSize > 0);
        if (pending) begin
            doPush  = 1'b1;
            pushSab = pendCmd;
            pending = 1'b0;
        end else if (sweeping) begin
            if (preSize < FIFO_DEPTH) begin
                doPush  = 1'b1;
                pushSab = 6'(sweepIdx);
                sweepIdx++;
                if (sweepIdx == 64) begin
                    sweeping = 1'b0;
                    lastAlu  = '0;
                end
            end
        end else if (bus.sweep_start) begin
            sweeping = 1'b1;
            sweepIdx = 0;
            lastAlu  = '0;
        end else if (bus.cmd_valid && preSize < FIFO_DEPTH) begin
            pending = 1'b1;
            pendCmd = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
            lastAlu = pendCmd;
        end
        if (doPop)  void'(expQ.pop_front());
        if (doPush) expQ.push_back(entryOf(pushSab));
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [9:0] expHead;
        logic [5:0] expAlu;
        expHead = (expQ.size() > 0) ? expQ[0] : 10'd0;
        expAlu  = sweeping ? 6'(sweepIdx) : lastAlu;
        checkVal("res_valid",  32'(bus.res_valid),  32'(expQ.size() > 0));
        checkVal("res_data",   32'(bus.res_data),   32'(expHead));
        checkVal("fifo_count", 32'(bus.fifo_count), 32'(expQ.size()));
        checkVal("busy",       32'(bus.busy),       32'(sweeping || pending));
        checkVal("alu_sab",    32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'(expAlu));
    endtask

    // Called at a falling edge: drive inputs, check cmd_ready, clock once, check outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [1:0] a,
                                 input logic [1:0] b, input logic sw, input logic rr,
                                 output bit accepted);
        bus.cmd_valid   = v;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.sweep_start = sw;
        bus.res_ready   = rr;
        #1;
        checkVal("cmd_ready", 32'(bus.cmd_ready), 32'(expCmdReady()));
        accepted = v && !sw && expCmdReady();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input logic rr);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, rr, acc);
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic rr);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b1, op, a, b, 1'b0, rr, acc);
        checkVal("cmd_accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit         acc;
        bit         seen;
        int         popped;
        logic [9:0] firstD, lastD;
        logic [3:0] nib [3];
        logic [1:0] rOp, rA, rB;
        logic       rV, rSw, rRr;

        nib = '{4'h5, 4'h2, 4'h2};
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.sweep_start = 1'b0;
        bus.res_ready   = 1'b0;
        modelReset();

        $display("[TB] reset");
        @(negedge clk);
        checkVal("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] single command");
        applyStimulus(1'b1, 2'd3, 2'd3, 2'd3, 1'b0, 1'b1, acc);
        checkVal("single_alu_sab", 32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'h3F);
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, acc);
        checkVal("single_res_data", 32'(bus.res_data), 32'h3F9);
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, acc);
        checkVal("single_count_drained", 32'(bus.fifo_count), 32'd0);

        $display("[TB] back-to-back commands");
        sendCmd(2'd2, 2'd3, 2'd2, 1'b0);
        sendCmd(2'd0, 2'd1, 2'd0, 1'b0);
        sendCmd(2'd1, 2'd3, 2'd1, 1'b0);
        idle(1, 1'b0);
        checkVal("b2b_count", 32'(bus.fifo_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkVal("b2b_result", 32'(bus.res_data[3:0]), 32'(nib[i]));
            idle(1, 1'b1);
        end

        $display("[TB] full FIFO backpressure");
        for (int i = 0; i < 4; i++) sendCmd(2'(i), 2'(i + 1), 2'(3 - i), 1'b0);
        idle(1, 1'b0);
        checkVal("full_count", 32'(bus.fifo_count), 32'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b1, acc);
        sendCmd(2'd0, 2'd2, 2'd1, 1'b0);
        idle(8, 1'b1);

        $display("[TB] sweep with free-running consumer");
        seen   = 1'b0;
        popped = 0;
        firstD = '0;
        lastD  = '0;
        for (int i = 0; i < 80; i++) begin
            if (bus.res_valid === 1'b1) begin
                if (!seen) firstD = bus.res_data;
                seen  = 1'b1;
                lastD = bus.res_data;
                popped++;
            end
            applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, (i == 0), 1'b1, acc);
        end
        checkVal("sweep_first", 32'(firstD), 32'h003);
        checkVal("sweep_last", 32'(lastD), 32'h3F9);
        checkVal("sweep_pops", 32'(popped), 32'd64);

        $display("[TB] sweep with stalled consumer");
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, acc);
        idle(10, 1'b0);
        checkVal("stall_alu_frozen", 32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'd4);
        checkVal("stall_count", 32'(bus.fifo_count), 32'd4);
        idl_release: idle(80, 1'b1);
        checkVal("stall_busy_done", 32'(bus.busy), 32'd0);

        $display("[TB] sweep priority and mid-sweep reset");
        applyStimulus(1'b1, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, acc);
        checkVal("sweep_wins_alu", 32'({bus.alu_s, bus.alu_a, bus.alu_b}), 32'd0);
        idle(6, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkVal("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            rV  = 1'($urandom_range(0, 1));
            rOp = 2'($urandom_range(0, 3));
            rA  = 2'($urandom_range(0, 3));
            rB  = 2'($urandom_range(0, 3));
            rSw = ($urandom_range(0, 39) == 0);
            rRr = ($urandom_range(0, 3) != 0);
            applyStimulus(rV, rOp, rA, rB, rSw, rRr, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
